// File: rtl/demux_scheduler.sv
// One-entry hold register that steers each accepted word to one of four channels,
// either by explicit destination or by burst round-robin over the enabled channels.
module demux_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] i_Data,
  input  logic [1:0]       i_Dest,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic             i_RR_Mode,
  input  logic [3:0]       i_Chan_En,
  output logic [3:0]       o_Valid,
  input  logic [3:0]       i_Ready,
  output logic [WIDTH-1:0] o_Data0,
  output logic [WIDTH-1:0] o_Data1,
  output logic [WIDTH-1:0] o_Data2,
  output logic [WIDTH-1:0] o_Data3,
  output logic             o_Drop
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;

  logic       full, xfer, rdy, accept, discard, load;
  logic [1:0] dest;
  logic [7:0] cnt_new;

  // First enabled channel at offsets first..3 from base (mod 4); base if none.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] en,
                                         input int unsigned first);
    logic [1:0] r;
    logic [1:0] c;
    logic       found;
    r     = base;
    found = 1'b0;
    for (int unsigned i = first; i < 4; i++) begin
      c = base + 2'(i);
      if (!found && en[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    full    = (state_q == FULL);
    xfer    = full & i_Ready[sel_q];
    rdy     = i_Rst_L & (~full | i_Ready[sel_q]) & ~(i_RR_Mode & ~|i_Chan_En);
    accept  = i_Valid & rdy;
    dest    = i_RR_Mode ? rr_pick(ptr_q, i_Chan_En, 0) : i_Dest;
    // A fixed-mode word to a disabled channel is consumed but never loaded.
    discard = accept & ~i_RR_Mode & ~i_Chan_En[i_Dest];
    load    = accept & ~discard;

    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      state_d = FULL;
      data_d  = i_Data;
      sel_d   = dest;
    end else if (xfer) begin
      state_d = EMPTY;
    end
    drop_d = discard;

    cnt_new = (dest != ptr_q) ? 8'd1 : cnt_q + 8'd1;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!i_RR_Mode) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_new == 8'(BURST_LEN)) begin
        ptr_d = rr_pick(dest, i_Chan_En, 1);
        cnt_d = '0;
      end else begin
        ptr_d = dest;
        cnt_d = cnt_new;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      o_Valid[k] = full & (sel_q == 2'(k));
    end
    o_Data0 = o_Valid[0] ? data_q : '0;
    o_Data1 = o_Valid[1] ? data_q : '0;
    o_Data2 = o_Valid[2] ? data_q : '0;
    o_Data3 = o_Valid[3] ? data_q : '0;
    o_Drop  = drop_q;
    o_Ready = rdy;
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: vector table feeding a delivery scoreboard, plus
// hand-written reset, backpressure, drop and mid-operation reset sequences.
module tb_demux_scheduler;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [7:0] i_Data;
  logic [1:0] i_Dest;
  logic       i_Valid;
  logic       o_Ready;
  logic       i_RR_Mode;
  logic [3:0] i_Chan_En;
  logic [3:0] o_Valid;
  logic [3:0] i_Ready;
  logic [7:0] o_Data0, o_Data1, o_Data2, o_Data3;
  logic       o_Drop;

  int errors = 0;
  int checks = 0;

  always #5 i_Clk = ~i_Clk;

  demux_scheduler #(.WIDTH(8), .BURST_LEN(2)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Data(i_Data), .i_Dest(i_Dest),
    .i_Valid(i_Valid), .o_Ready(o_Ready), .i_RR_Mode(i_RR_Mode),
    .i_Chan_En(i_Chan_En), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Data0(o_Data0), .o_Data1(o_Data1), .o_Data2(o_Data2), .o_Data3(o_Data3),
    .o_Drop(o_Drop)
  );

  typedef struct { logic [1:0] ch; logic [7:0] d; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] dest;
    logic       rr;
    logic [3:0] en;
    logic [1:0] ch;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Delivery monitor: a transfer happens at the next rising edge.
  always @(negedge i_Clk) begin
    if (i_Rst_L === 1'b1 && (o_Valid & i_Ready) != 4'b0000) begin
      logic [7:0] got[4];
      logic [7:0] want[4];
      exp_t e;
      got = '{o_Data0, o_Data1, o_Data2, o_Data3};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: o_Valid=%b with empty scoreboard", o_Valid);
      end else begin
        logic bad;
        e = sb.pop_front();
        bad = (o_Valid !== (4'b0001 << e.ch));
        for (int k = 0; k < 4; k++) begin
          want[k] = (k == int'(e.ch)) ? e.d : 8'h00;
          if (got[k] !== want[k]) bad = 1'b1;
        end
        if (bad) begin
          errors++;
          $display("FAIL delivery: o_Valid=%b data=%h/%h/%h/%h expected ch%0d data %h",
                   o_Valid, got[0], got[1], got[2], got[3], e.ch, e.d);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] dst, input logic [1:0] ch,
                      input bit deliver, output int waited);
    i_Valid = 1'b1;
    i_Data  = d;
    i_Dest  = dst;
    waited  = 0;
    @(negedge i_Clk);
    while (!o_Ready && waited < 50) begin
      waited++;
      @(negedge i_Clk);
    end
    if (!o_Ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end else if (deliver) begin
      sb.push_back('{ch, d});
    end
    @(posedge i_Clk);
    #1;
    i_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(posedge i_Clk);
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int w;
    int stalls;

    tbl[0]  = '{8'hA1, 2'd2, 1'b0, 4'hF, 2'd2};
    tbl[1]  = '{8'hB2, 2'd0, 1'b0, 4'hF, 2'd0};
    tbl[2]  = '{8'hC3, 2'd3, 1'b0, 4'hF, 2'd3};
    tbl[3]  = '{8'hD4, 2'd1, 1'b0, 4'hF, 2'd1};
    tbl[4]  = '{8'h01, 2'd3, 1'b1, 4'hF, 2'd0};
    tbl[5]  = '{8'h02, 2'd3, 1'b1, 4'hF, 2'd0};
    tbl[6]  = '{8'h03, 2'd3, 1'b1, 4'hF, 2'd1};
    tbl[7]  = '{8'h04, 2'd3, 1'b1, 4'hF, 2'd1};
    tbl[8]  = '{8'h05, 2'd0, 1'b1, 4'hF, 2'd2};
    tbl[9]  = '{8'h06, 2'd0, 1'b1, 4'hF, 2'd2};
    tbl[10] = '{8'h07, 2'd0, 1'b1, 4'hF, 2'd3};
    tbl[11] = '{8'h08, 2'd0, 1'b1, 4'hF, 2'd3};
    tbl[12] = '{8'h01, 2'd0, 1'b1, 4'hA, 2'd1};
    tbl[13] = '{8'h02, 2'd0, 1'b1, 4'hA, 2'd1};
    tbl[14] = '{8'h03, 2'd0, 1'b1, 4'hA, 2'd3};
    tbl[15] = '{8'h04, 2'd0, 1'b1, 4'hA, 2'd3};
    tbl[16] = '{8'h05, 2'd0, 1'b1, 4'hA, 2'd1};
    tbl[17] = '{8'h06, 2'd0, 1'b1, 4'hA, 2'd1};
    tbl[18] = '{8'h90, 2'd2, 1'b0, 4'hF, 2'd2};
    tbl[19] = '{8'h91, 2'd2, 1'b1, 4'hF, 2'd0};

    i_Rst_L   = 1'b0;
    i_Valid   = 1'b1;
    i_Data    = 8'h11;
    i_Dest    = 2'd0;
    i_RR_Mode = 1'b0;
    i_Chan_En = 4'hF;
    i_Ready   = 4'hF;

    repeat (3) @(negedge i_Clk);
    check("rst_ready", o_Ready, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_data", {o_Data0, o_Data1, o_Data2, o_Data3}, 0);
    check("rst_drop", o_Drop, 0);
    @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    send(8'h11, 2'd0, 2'd0, 1'b1, w);
    check("ready_after_release", w, 0);
    drain();

    stalls = 0;
    foreach (tbl[i]) begin
      i_RR_Mode = tbl[i].rr;
      i_Chan_En = tbl[i].en;
      send(tbl[i].data, tbl[i].dest, tbl[i].ch, 1'b1, w);
      stalls += w;
    end
    check("no_bubbles", stalls, 0);
    drain();

    i_RR_Mode = 1'b0;
    i_Chan_En = 4'b1110;
    send(8'h77, 2'd0, 2'd0, 1'b0, w);
    check("drop_pulse", o_Drop, 1);
    check("drop_no_valid", o_Valid, 0);
    @(posedge i_Clk);
    #1;
    check("drop_one_cycle", o_Drop, 0);
    check("drop_still_idle", o_Valid, 0);

    i_RR_Mode = 1'b1;
    i_Chan_En = 4'b0000;
    i_Valid   = 1'b1;
    #1;
    check("rr_mask0_ready", o_Ready, 0);
    i_Valid = 1'b0;
    @(posedge i_Clk);
    #1;

    i_RR_Mode = 1'b0;
    i_Chan_En = 4'hF;
    i_Ready   = 4'b1101;
    send(8'h5A, 2'd1, 2'd1, 1'b1, w);
    i_Valid = 1'b1;
    i_Data  = 8'h6B;
    i_Dest  = 2'd2;
    repeat (5) begin
      @(negedge i_Clk);
      check("stall_valid", o_Valid, 4'b0010);
      check("stall_data", o_Data1, 8'h5A);
      check("stall_ready", o_Ready, 0);
    end
    @(posedge i_Clk);
    #1;
    i_Ready = 4'hF;
    send(8'h6B, 2'd2, 2'd2, 1'b1, w);
    check("accept_on_release", w, 0);
    drain();

    i_Ready = 4'b0111;
    send(8'hE3, 2'd3, 2'd3, 1'b1, w);
    check("held_ch3", o_Valid, 4'b1000);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check("async_rst_valid", o_Valid, 0);
    check("async_rst_data3", o_Data3, 0);
    sb.delete();
    @(posedge i_Clk);
    #1;
    i_Rst_L   = 1'b1;
    i_RR_Mode = 1'b1;
    i_Ready   = 4'hF;
    send(8'h3C, 2'd2, 2'd0, 1'b1, w);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
